// File: rtl/nmcu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nmcu_pkg : shared memory request/response types and arbiter states    |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package nmcu_pkg;

    localparam int ADDR_WIDTH    = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int LEN_WIDTH     = 8;
    localparam int NUM_CACHE_REQ = 2;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic                  write_en;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] rdata;
    } mem_resp_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_port_arbiter_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, search starts at rr_ptr  |
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_pending,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any_valid
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = IDX_W'((int'(i_rr_ptr) + i) % NUM_REQ);
            if (!w_found && i_pending[w_idx]) begin
                o_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign o_any_valid = |i_pending;

endmodule
`default_nettype wire

// File: rtl/cache_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cache_port_arbiter : N requesters share one cache port, one in flight |
// | Revision           : 1.0                                              |
// +-----------------------------------------------------------------------+
module cache_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = nmcu_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
    parameter int LEN_WIDTH  = nmcu_pkg::LEN_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  nmcu_pkg::mem_req_t            req_i [NUM_REQ],
    output nmcu_pkg::mem_resp_t           resp_o [NUM_REQ],
    output nmcu_pkg::mem_req_t            cache_req_o,
    input  nmcu_pkg::mem_resp_t           cache_resp_i,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic                          busy_o,
    output logic                          err_o
);
    import nmcu_pkg::*;

    localparam int c_IDX_W = $clog2(NUM_REQ);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [c_IDX_W-1:0]    r_grant;
    logic [c_IDX_W-1:0]    r_rr_ptr;
    logic                  r_err;

    logic [NUM_REQ-1:0]    r_slot_vld;
    logic [ADDR_WIDTH-1:0] r_slot_addr  [NUM_REQ];
    logic [LEN_WIDTH-1:0]  r_slot_len   [NUM_REQ];
    logic                  r_slot_we    [NUM_REQ];
    logic [DATA_WIDTH-1:0] r_slot_wdata [NUM_REQ];

    logic [c_IDX_W-1:0]    w_winner;
    logic                  w_any_valid;
    logic                  w_resp_hit;
    logic                  w_stray;
    logic                  w_overflow;
    logic [NUM_REQ-1:0]    w_clear;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr (
        .i_pending   (r_slot_vld),
        .i_rr_ptr    (r_rr_ptr),
        .o_winner    (w_winner),
        .o_any_valid (w_any_valid)
    );

    assign w_resp_hit = cache_resp_i.valid && (r_state != IDLE);
    assign w_stray    = cache_resp_i.valid && (r_state == IDLE);

    // A slot being cleared this cycle may be refilled without error (set wins).
    always_comb begin
        w_clear    = '0;
        w_overflow = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_clear[k] = w_resp_hit && (r_grant == c_IDX_W'(k));
            if (req_i[k].valid && r_slot_vld[k] && !w_clear[k]) begin
                w_overflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_vld <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                r_slot_addr[k]  <= '0;
                r_slot_len[k]   <= '0;
                r_slot_we[k]    <= 1'b0;
                r_slot_wdata[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_i[k].valid && (!r_slot_vld[k] || w_clear[k])) begin
                    r_slot_vld[k]   <= 1'b1;
                    r_slot_addr[k]  <= req_i[k].addr;
                    r_slot_len[k]   <= req_i[k].len;
                    r_slot_we[k]    <= req_i[k].write_en;
                    r_slot_wdata[k] <= req_i[k].wdata;
                end else if (w_clear[k]) begin
                    r_slot_vld[k]   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= r_err | w_overflow | w_stray;
            if (r_state == IDLE && w_any_valid) begin
                r_grant <= w_winner;
            end
            if (w_resp_hit) begin
                r_rr_ptr <= (r_grant == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cache_req_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            resp_o[k] = '0;
        end
        case (r_state)
            IDLE: begin
                if (w_any_valid) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                cache_req_o.valid    = 1'b1;
                cache_req_o.addr     = r_slot_addr[r_grant];
                cache_req_o.len      = r_slot_len[r_grant];
                cache_req_o.write_en = r_slot_we[r_grant];
                cache_req_o.wdata    = r_slot_wdata[r_grant];
                w_state_nxt          = w_resp_hit ? IDLE : WAIT_RESP;
            end
            WAIT_RESP: begin
                if (w_resp_hit) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_resp_hit) begin
            resp_o[r_grant] = cache_resp_i;
        end
    end

    assign grant_id_o = (r_state == IDLE) ? '0 : r_grant;
    assign busy_o     = (r_state != IDLE);
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_cache_port_arbiter : scoreboard bench against a transaction model  |
// | Revision              : 1.0                                           |
// +-----------------------------------------------------------------------+
module tb_cache_port_arbiter;
    import nmcu_pkg::*;

    localparam int N  = 2;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    mem_req_t      req_i [N];
    mem_resp_t     resp_o [N];
    mem_req_t      cache_req_o;
    mem_resp_t     cache_resp_i;
    logic [IW-1:0] grant_id_o;
    logic          busy_o;
    logic          err_o;

    cache_port_arbiter #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .resp_o       (resp_o),
        .cache_req_o  (cache_req_o),
        .cache_resp_i (cache_resp_i),
        .grant_id_o   (grant_id_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; mem_req_t req; } exp_req_t;
    typedef struct { int cyc; int idx; mem_resp_t resp; } exp_resp_t;

    exp_req_t  q_req [$];
    exp_resp_t q_resp [$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: port phase 0=free, 1=request on the bus, 2=awaiting data
    int       m_phase, m_owner, m_ptr, m_wcnt;
    bit       m_err;
    bit       m_pend [N];
    mem_req_t m_slot [N];

    mem_req_t        drv_req [N];
    bit              force_resp;
    logic [31:0]     resp_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic mem_req_t mk(input logic [31:0] addr, input bit we, input logic [31:0] wd);
        mem_req_t r;
        r = '0;
        r.valid = 1'b1; r.addr = addr; r.len = 8'd1; r.write_en = we; r.wdata = wd;
        return r;
    endfunction

    function automatic mem_req_t rand_req();
        mem_req_t r;
        r.valid    = 1'b1;
        r.addr     = $urandom;
        r.len      = LEN_WIDTH'($urandom);
        r.write_en = 1'($urandom_range(1));
        r.wdata    = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_ptr = 0; m_wcnt = 0; m_err = 0;
        for (int k = 0; k < N; k++) begin
            m_pend[k] = 0;
            m_slot[k] = '0;
        end
        q_req.delete();
        q_resp.delete();
    endtask

    // Advance the model across the edge that consumed the inputs still on the pins.
    task automatic model_edge();
        bit rv;
        int clr;
        rv  = cache_resp_i.valid;
        clr = (m_phase != 0 && rv) ? m_owner : -1;
        if (m_phase == 0 && rv) m_err = 1;
        for (int k = 0; k < N; k++)
            if (req_i[k].valid && m_pend[k] && clr != k) m_err = 1;
        case (m_phase)
            0: begin
                for (int j = N - 1; j >= 0; j--)
                    if (m_pend[(m_ptr + j) % N]) begin
                        m_owner = (m_ptr + j) % N;
                        m_phase = 1;
                    end
            end
            1: begin
                m_phase = rv ? 0 : 2;
                m_wcnt  = 0;
            end
            default: begin
                if (rv) m_phase = 0;
                else    m_wcnt++;
            end
        endcase
        if (clr >= 0) begin
            m_ptr = (clr + 1) % N;
            m_pend[clr] = 0;
        end
        for (int k = 0; k < N; k++)
            if (req_i[k].valid && !m_pend[k]) begin
                m_pend[k] = 1;
                m_slot[k] = req_i[k];
            end
    endtask

    task automatic model_now();
        exp_req_t  er;
        exp_resp_t es;
        if (m_phase == 1) begin
            er.cyc = cyc; er.req = m_slot[m_owner]; er.req.valid = 1'b1;
            q_req.push_back(er);
        end
        if (m_phase != 0 && cache_resp_i.valid) begin
            es.cyc = cyc; es.idx = m_owner; es.resp = cache_resp_i;
            q_resp.push_back(es);
        end
    endtask

    task automatic step(input bit rnd);
        bit rv;
        int clr;
        @(posedge clk);
        #1;
        model_edge();
        cyc++;
        if (rnd) rv = (m_phase != 0) && ($urandom_range(2) == 0);
        else     rv = (m_phase == 2 && m_wcnt >= 1) || force_resp;
        force_resp = 0;
        cache_resp_i.valid = rv;
        cache_resp_i.rdata = rv ? (rnd ? $urandom : resp_data) : '0;
        clr = (m_phase != 0 && rv) ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (rnd) req_i[k] = ((!m_pend[k] || clr == k) && $urandom_range(3) == 0) ? rand_req() : '0;
            else     req_i[k] = drv_req[k];
            drv_req[k] = '0;
        end
        model_now();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) req_i[k] = '0;
        cache_resp_i = '0;
        model_reset();
        #1;
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_cache_req", 128'(cache_req_o), 128'(0));
        chk("rst_grant", 128'(grant_id_o), 128'(0));
        chk("rst_err", 128'(err_o), 128'(0));
        for (int k = 0; k < N; k++) chk("rst_resp", 128'(resp_o[k]), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares the DUT against whatever the model queued for this cycle.
    initial begin
        mem_req_t  ec;
        mem_resp_t ers [N];
        exp_resp_t e;
        forever begin
            @(negedge clk);
            ec = '0;
            if (q_req.size() > 0 && q_req[0].cyc == cyc) ec = q_req.pop_front().req;
            chk("cache_req", 128'(cache_req_o), 128'(ec));
            for (int k = 0; k < N; k++) ers[k] = '0;
            if (q_resp.size() > 0 && q_resp[0].cyc == cyc) begin
                e = q_resp.pop_front();
                ers[e.idx] = e.resp;
            end
            for (int k = 0; k < N; k++) chk("resp", 128'(resp_o[k]), 128'(ers[k]));
            chk("grant_id", 128'(grant_id_o), 128'(m_phase != 0 ? m_owner : 0));
            chk("busy", 128'(busy_o), 128'(m_phase != 0));
            chk("err", 128'(err_o), 128'(m_err));
        end
    end

    initial begin
        cache_resp_i = '0;
        for (int k = 0; k < N; k++) begin
            req_i[k]   = '0;
            drv_req[k] = '0;
        end
        force_resp = 0;
        resp_data  = '0;
        model_reset();
        do_reset();

        // single read, data 42 two cycles after issue
        resp_data  = 32'd42;
        drv_req[0] = mk(32'h10, 1'b0, 32'h0);
        step(0);
        repeat (6) step(0);

        // contention from rr_ptr=0, then a lone request, then a pair starting at 1
        do_reset();
        resp_data  = 32'h1234;
        drv_req[0] = mk(32'h20, 1'b0, 32'h0);
        drv_req[1] = mk(32'h30, 1'b0, 32'h0);
        step(0);
        repeat (10) step(0);
        drv_req[0] = mk(32'h50, 1'b0, 32'h0);
        step(0);
        repeat (6) step(0);
        drv_req[0] = mk(32'h60, 1'b0, 32'h0);
        drv_req[1] = mk(32'h70, 1'b0, 32'h0);
        step(0);
        repeat (12) step(0);

        // write from requester 1
        drv_req[1] = mk(32'h40, 1'b1, 32'd7);
        step(0);
        repeat (6) step(0);

        // requester 0 re-asserts in its own response cycle
        drv_req[0] = mk(32'h80, 1'b0, 32'h0);
        step(0);
        repeat (3) step(0);
        drv_req[0] = mk(32'h84, 1'b0, 32'h0);
        step(0);
        repeat (8) step(0);

        // randomized traffic, no protocol violations
        repeat (1500) step(1);
        repeat (20) step(0);

        // double request into a full slot
        drv_req[0] = mk(32'h90, 1'b0, 32'h0);
        step(0);
        drv_req[0] = mk(32'h94, 1'b0, 32'h0);
        step(0);
        repeat (8) step(0);

        // response while idle
        do_reset();
        force_resp = 1;
        step(0);
        repeat (3) step(0);

        // reset in the middle of a transaction, then a late response
        do_reset();
        drv_req[0] = mk(32'hA0, 1'b0, 32'h0);
        step(0);
        repeat (3) step(0);
        do_reset();
        force_resp = 1;
        step(0);
        repeat (3) step(0);

        @(posedge clk);
        #1;
        chk("q_req_drained", 128'(q_req.size()), 128'(0));
        chk("q_resp_drained", 128'(q_resp.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
